// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and sequencer wrapped around the multi-cycle unsigned divider.
// Optional divide-by-zero trap is enabled with the DIV_ZERO_TRAP_EN macro.
module hilo_div_ctrl #(
  parameter int unsigned ITER      = 32,
  parameter logic [5:0]  DIVU_CODE = 6'b011011,
  parameter logic [5:0]  OUT_CODE  = 6'b111111,
  parameter logic [5:0]  MFHI_CODE = 6'b010000,
  parameter logic [5:0]  MFLO_CODE = 6'b010010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  funct,
  input  logic        ex_valid,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [31:0] div_dataA,
  output logic [31:0] div_dataB,
  output logic [5:0]  div_signal,
  input  logic [63:0] div_dataOut,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic        div_zero
`endif
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    ZTRAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic accept;
  assign accept = ex_valid && (funct == DIVU_CODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_signal = OUT_CODE;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = opA;
          opb_d   = opB;
          state_d = LOAD;
`ifdef DIV_ZERO_TRAP_EN
          if (opB == 32'd0) state_d = ZTRAP;
`endif
        end
      end
      LOAD: begin
        // Divider samples div_dataA/B on this edge while Signal is OUT_CODE.
        count_d = '0;
        state_d = RUN;
      end
      RUN: begin
        div_signal = DIVU_CODE;
        count_d    = count_q + CW'(1);
        if (count_q == LAST_COUNT) state_d = CAPTURE;
      end
      CAPTURE: begin
        hi_d    = div_dataOut[63:32];
        lo_d    = div_dataOut[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZTRAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign div_dataA = opa_q;
  assign div_dataB = opb_q;
  assign stall     = (state_q != IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

`ifdef DIV_ZERO_TRAP_EN
  assign div_zero = (state_q == ZTRAP);
`endif

  always_comb begin
    rd_data = 32'd0;
    if (funct == MFHI_CODE)      rd_data = hi_q;
    else if (funct == MFLO_CODE) rd_data = lo_q;
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl with a restoring-division model standing in for the divider.
module tb_hilo_div_ctrl;

  localparam logic [5:0] DIVU_CODE = 6'b011011;
  localparam logic [5:0] OUT_CODE  = 6'b111111;
  localparam logic [5:0] MFHI_CODE = 6'b010000;
  localparam logic [5:0] MFLO_CODE = 6'b010010;

  logic        clk;
  logic        reset;
  logic [5:0]  funct;
  logic        ex_valid;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] div_dataA;
  logic [31:0] div_dataB;
  logic [5:0]  div_signal;
  logic [63:0] div_dataOut;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero;
`endif

  hilo_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .funct      (funct),
    .ex_valid   (ex_valid),
    .opA        (opA),
    .opB        (opB),
    .div_dataA  (div_dataA),
    .div_dataB  (div_dataB),
    .div_signal (div_signal),
    .div_dataOut(div_dataOut),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .rd_data    (rd_data)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: loads operands whenever Signal is OUT_CODE, one restoring step per DIVU cycle.
  logic [63:0] model_acc;
  logic [31:0] model_div;
  always @(posedge clk) begin
    logic [63:0] t;
    if (div_signal == DIVU_CODE) begin
      t = {model_acc[62:0], 1'b0};
      if (t[63:32] >= model_div) begin
        t[63:32] = t[63:32] - model_div;
        t[0] = 1'b1;
      end
      model_acc <= t;
    end else begin
      model_acc <= {32'd0, div_dataA};
      model_div <= div_dataB;
    end
  end
  assign div_dataOut = model_acc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; DIVU is presented now and accepted on the next posedge.
  task automatic run_divu(input logic [31:0] a, input logic [31:0] b, input bit hold);
    int stalls;
    logic [63:0] exp;
    funct = DIVU_CODE; ex_valid = 1'b1; opA = a; opB = b;
    sb.push_back({a % b, a / b});
    @(posedge clk); #1;
    opA = $urandom; opB = $urandom;
    if (!hold) begin funct = 6'h00; ex_valid = 1'b0; end
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall) break;
      if (k == 5) chk("div_dataA_latched", {32'd0, div_dataA}, {32'd0, a});
      stalls++;
    end
    funct = 6'h00; ex_valid = 1'b0;
    chk("stall_cycles", 64'(stalls), 64'd34);
    chk("done_pulse", {63'd0, done}, 64'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      exp = sb.pop_front();
      chk("hilo_scoreboard", {hi, lo}, exp);
    end
    $display("divu %0d / %0d -> lo=%0d hi=%0d stall_cycles=%0d done=%0b", a, b, lo, hi, stalls, done);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    bit          b2b;
    bit          hold;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b1, 1'b0};
    vecs[3] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b1};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
    vecs[6] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0, 1'b0};

    reset = 1'b0; funct = 6'h00; ex_valid = 1'b0; opA = '0; opB = '0;
    #2 reset = 1'b1;
    #1;
    funct = MFHI_CODE;
    #1;
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_signal", {58'd0, div_signal}, {58'd0, OUT_CODE});
    chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
    funct = 6'h00;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].b2b) @(negedge clk);
      run_divu(vecs[i].a, vecs[i].b, vecs[i].hold);
      chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      if (i == 0) begin
        funct = MFLO_CODE; ex_valid = 1'b1; #1;
        chk("mflo_rd_data", {32'd0, rd_data}, 64'd14);
        funct = MFHI_CODE; #1;
        chk("mfhi_rd_data", {32'd0, rd_data}, 64'd2);
        funct = 6'h21; #1;
        chk("other_rd_data", {32'd0, rd_data}, 64'd0);
        funct = 6'h00; ex_valid = 1'b0;
      end
      if (i + 1 < 7 && !vecs[i + 1].b2b) begin
        @(negedge clk);
        chk($sformatf("vec%0d_done_drop", i), {62'd0, done, stall}, 64'd0);
      end
    end

    // Non-accepting inputs must leave the controller idle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      case (k % 3)
        0: begin funct = DIVU_CODE; ex_valid = 1'b0; end
        1: begin funct = MFHI_CODE; ex_valid = 1'b1; end
        default: begin funct = 6'h1A; ex_valid = 1'b1; end
      endcase
      opA = $urandom; opB = $urandom;
      @(negedge clk);
      chk($sformatf("idle%0d_stall", k), {63'd0, stall}, 64'd0);
      chk($sformatf("idle%0d_signal", k), {58'd0, div_signal}, {58'd0, OUT_CODE});
      chk($sformatf("idle%0d_hilo", k), {hi, lo}, {32'd678, 32'd12345});
      $display("idle funct=%0h ex_valid=%0b -> stall=%0b signal=%0h", funct, ex_valid, stall, div_signal);
    end
    funct = 6'h00; ex_valid = 1'b0;

    // Reset during RUN cycle 10.
    @(negedge clk);
    funct = DIVU_CODE; ex_valid = 1'b1; opA = 32'd100; opB = 32'd7;
    @(posedge clk); #1;
    funct = 6'h00; ex_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("midrun_signal", {58'd0, div_signal}, {58'd0, DIVU_CODE});
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_stall", {63'd0, stall}, 64'd0);
    chk("midrun_reset_done", {63'd0, done}, 64'd0);
    chk("midrun_reset_hilo", {hi, lo}, 64'd0);
    $display("reset mid-run -> stall=%0b done=%0b hi=%0d lo=%0d", stall, done, hi, lo);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_stall", {63'd0, stall}, 64'd0);
    run_divu(32'd1000, 32'd33, 1'b0);
    chk("post_reset_lo", {32'd0, lo}, 64'd30);
    chk("post_reset_hi", {32'd0, hi}, 64'd10);

`ifdef DIV_ZERO_TRAP_EN
    @(negedge clk);
    run_divu(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    funct = DIVU_CODE; ex_valid = 1'b1; opA = 32'd42; opB = 32'd0;
    @(posedge clk); #1;
    funct = 6'h00; ex_valid = 1'b0;
    @(negedge clk);
    chk("ztrap_stall", {63'd0, stall}, 64'd1);
    chk("ztrap_div_zero", {63'd0, div_zero}, 64'd1);
    chk("ztrap_signal", {58'd0, div_signal}, {58'd0, OUT_CODE});
    @(negedge clk);
    chk("ztrap_end", {61'd0, stall, div_zero, done}, 64'd0);
    chk("ztrap_hilo", {hi, lo}, {32'd2, 32'd14});
    $display("divu 42 / 0 trap -> hi=%0d lo=%0d stall=%0b", hi, lo, stall);
`endif

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
